// File: rtl/game_timing_pkg.sv
// Timing constants shared by the tick generator and the ball/paddle movers.
// Defaults give a 3 Hz base rate at 100 MHz with seven speed steps.
package game_timing_pkg;

    localparam int unsigned CLK_HZ        = 100_000_000;
    localparam int unsigned DEF_CNT_W     = 27;
    localparam int unsigned DEF_BASE_DIV  = 33_333_333;
    localparam int unsigned DEF_STEP_DIV  = 3_333_333;
    localparam int unsigned DEF_MAX_LEVEL = 7;

    // Smallest width that can hold 0..max_level.
    function automatic int unsigned level_width(input int unsigned max_level);
        return (max_level < 2) ? 1 : $clog2(max_level + 1);
    endfunction

    localparam int unsigned DEF_LVL_W = level_width(DEF_MAX_LEVEL);

    // Per-cycle action on the level/divisor state, in priority order.
    typedef enum logic [1:0] {
        CTRL_RUN,
        CTRL_STEP,
        CTRL_BASE
    } ctrl_e;

endpackage

// File: rtl/tick_prescaler.sv
// Period counter: counts enabled cycles 0..div_i-1 and flags the terminal count.
// A restart forces the count back to zero and takes priority over counting.
module tick_prescaler
    import game_timing_pkg::*;
#(
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable_i,
    input  logic             restart_i,
    input  logic [CNT_W-1:0] div_i,
    output logic             wrap_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             terminal;

    assign terminal = (cnt_q == div_i - CNT_W'(1));
    assign wrap_o   = enable_i & terminal;

    // NOTE: cnt_d takes a default before any branch so no path leaves it unassigned (no latch).
    always_comb begin
        cnt_d = cnt_q;
        if (restart_i) begin
            cnt_d = '0;
        end else if (enable_i) begin
            cnt_d = terminal ? '0 : cnt_q + CNT_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/game_tick_gen.sv
// Game-speed tick generator: one-cycle tick per period, speed levels that shorten
// the period, pause, speed reset, and a blink output toggling on every tick.
module game_tick_gen
    import game_timing_pkg::*;
#(
    parameter int unsigned CNT_W     = DEF_CNT_W,
    parameter int unsigned BASE_DIV  = DEF_BASE_DIV,
    parameter int unsigned STEP_DIV  = DEF_STEP_DIV,
    parameter int unsigned MAX_LEVEL = DEF_MAX_LEVEL,
    parameter int unsigned LVL_W     = DEF_LVL_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             speed_up,
    input  logic             speed_rst,
    output logic             tick,
    output logic             blink,
    output logic [LVL_W-1:0] level,
    output logic             at_max
);

    if (MAX_LEVEL < 1 || BASE_DIV < MAX_LEVEL * STEP_DIV + 2 ||
        64'(BASE_DIV) >= (64'd1 << CNT_W) || (64'd1 << LVL_W) <= 64'(MAX_LEVEL)) begin : g_bad_params
        $error("game_tick_gen: illegal parameter combination");
    end

    localparam logic [CNT_W-1:0] BASE_C = CNT_W'(BASE_DIV);
    localparam logic [CNT_W-1:0] STEP_C = CNT_W'(STEP_DIV);
    localparam logic [LVL_W-1:0] MAX_C  = LVL_W'(MAX_LEVEL);

    logic [CNT_W-1:0] div_q,   div_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             tick_q,  tick_d;
    logic             blink_q, blink_d;
    ctrl_e            ctrl;
    logic             restart;
    logic             wrap;

    // Speed reset beats speed-up; speed-up at the top level is ignored entirely.
    always_comb begin
        ctrl = CTRL_RUN;
        if (speed_rst) begin
            ctrl = CTRL_BASE;
        end else if (speed_up && (level_q < MAX_C)) begin
            ctrl = CTRL_STEP;
        end
    end

    assign restart = (ctrl != CTRL_RUN);

    tick_prescaler #(
        .CNT_W (CNT_W)
    ) u_prescaler (
        .clk       (clk),
        .reset     (reset),
        .enable_i  (enable),
        .restart_i (restart),
        .div_i     (div_q),
        .wrap_o    (wrap)
    );

    always_comb begin
        level_d = level_q;
        div_d   = div_q;
        blink_d = blink_q;
        tick_d  = 1'b0;
        unique case (ctrl)
            CTRL_BASE: begin
                level_d = '0;
                div_d   = BASE_C;
            end
            CTRL_STEP: begin
                level_d = level_q + LVL_W'(1);
                div_d   = div_q - STEP_C;
            end
            default: begin
                if (wrap) begin
                    tick_d  = 1'b1;
                    blink_d = ~blink_q;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q   <= BASE_C;
            level_q <= '0;
            tick_q  <= 1'b0;
            blink_q <= 1'b0;
        end else begin
            div_q   <= div_d;
            level_q <= level_d;
            tick_q  <= tick_d;
            blink_q <= blink_d;
        end
    end

    assign tick   = tick_q;
    assign blink  = blink_q;
    assign level  = level_q;
    assign at_max = (level_q == MAX_C);

endmodule

// File: tb/tb_game_tick_gen.sv
// Directed scenarios plus random control traffic against a period/phase reference model.
module tb_game_tick_gen;

    localparam int CNT_W     = 4;
    localparam int BASE_DIV  = 10;
    localparam int STEP_DIV  = 2;
    localparam int MAX_LEVEL = 3;
    localparam int LVL_W     = 2;

    logic             clk;
    logic             reset;
    logic             enable;
    logic             speed_up;
    logic             speed_rst;
    logic             tick;
    logic             blink;
    logic [LVL_W-1:0] level;
    logic             at_max;

    int checks = 0;
    int errors = 0;

    // Reference state: level, enabled cycles elapsed in the current period, outputs.
    int m_level;
    int m_phase;
    int m_tick;
    int m_blink;

    game_tick_gen #(
        .CNT_W     (CNT_W),
        .BASE_DIV  (BASE_DIV),
        .STEP_DIV  (STEP_DIV),
        .MAX_LEVEL (MAX_LEVEL),
        .LVL_W     (LVL_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .speed_up  (speed_up),
        .speed_rst (speed_rst),
        .tick      (tick),
        .blink     (blink),
        .level     (level),
        .at_max    (at_max)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int period(input int lvl);
        return BASE_DIV - lvl * STEP_DIV;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        if (reset) begin
            m_level = 0; m_phase = 0; m_tick = 0; m_blink = 0;
        end else if (speed_rst) begin
            m_level = 0; m_phase = 0; m_tick = 0;
        end else if (speed_up && m_level < MAX_LEVEL) begin
            m_level++; m_phase = 0; m_tick = 0;
        end else if (enable) begin
            m_phase++;
            if (m_phase == period(m_level)) begin
                m_phase = 0; m_tick = 1; m_blink = 1 - m_blink;
            end else begin
                m_tick = 0;
            end
        end else begin
            m_tick = 0;
        end
    endtask

    // Called at a falling edge: drive, clock, update model, check at the next falling edge.
    task automatic step(input logic en, input logic up, input logic srst, input logic rst);
        enable = en; speed_up = up; speed_rst = srst; reset = rst;
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("tick",   tick,   m_tick);
        check("blink",  blink,  m_blink);
        check("level",  level,  m_level);
        check("at_max", at_max, (m_level == MAX_LEVEL) ? 1 : 0);
    endtask

    task automatic gap_to_tick(output int g);
        g = -1;
        for (int k = 1; k <= 40; k++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0);
            if (tick === 1'b1) begin
                g = k;
                break;
            end
        end
    endtask

    task automatic run_to_phase(input int target, output bit hit);
        hit = 0;
        for (int k = 0; k < 40; k++) begin
            if (m_phase == target) begin
                hit = 1;
                break;
            end
            step(1'b1, 1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        int  ticks;
        int  first;
        int  g;
        bit  hit;
        int  saved_blink;
        int  r;

        enable = 1'b0; speed_up = 1'b0; speed_rst = 1'b0; reset = 1'b1;
        m_level = 0; m_phase = 0; m_tick = 0; m_blink = 0;
        @(negedge clk);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b1);

        // Free-running at level 0: ticks in cycles 10, 20, 30, 40.
        ticks = 0; first = -1;
        for (int k = 0; k < 40; k++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0);
            if (tick === 1'b1) begin
                ticks++;
                if (first < 0) first = k + 1;
            end
        end
        check("s1_tick_count", ticks, 4);
        check("s1_first_tick", first, BASE_DIV);
        check("s1_blink_after_4", blink, 0);

        // One speed-up mid-period: period restarts at 8.
        repeat (5) step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        gap_to_tick(g);
        check("s2_gap_level1", g, 8);
        gap_to_tick(g);
        check("s2_period_level1", g, 8);

        // Four pulses from level 0 spaced 20 apart; the last one is ignored at max.
        step(1'b1, 1'b0, 1'b1, 1'b0);
        for (int p = 0; p < 4; p++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0);
            repeat (19) step(1'b1, 1'b0, 1'b0, 1'b0);
        end
        check("s3_level_held", level, MAX_LEVEL);
        check("s3_at_max", at_max, 1);
        gap_to_tick(g);
        gap_to_tick(g);
        check("s3_period_max", g, 4);
        repeat (2) step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        gap_to_tick(g);
        check("s3_ignored_pulse_no_restart", g, 1);

        // Speed-up on the terminal-count cycle swallows that tick.
        step(1'b1, 1'b0, 1'b1, 1'b0);
        run_to_phase(BASE_DIV - 1, hit);
        check("s4_reached_terminal", hit, 1);
        saved_blink = m_blink;
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check("s4_tick_swallowed", tick, 0);
        check("s4_blink_kept", blink, saved_blink);
        gap_to_tick(g);
        check("s4_new_period", g, period(1));

        // Pause at phase 6 for 7 cycles, then finish the period.
        step(1'b1, 1'b0, 1'b1, 1'b0);
        run_to_phase(6, hit);
        check("s5_reached_phase6", hit, 1);
        ticks = 0;
        for (int k = 0; k < 7; k++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0);
            if (tick === 1'b1) ticks++;
        end
        check("s5_no_tick_paused", ticks, 0);
        gap_to_tick(g);
        check("s5_resume_gap", g, BASE_DIV - 6);

        // Simultaneous speed-up and speed reset at level 2; then reset mid-period.
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check("s6_level2", level, 2);
        repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        check("s6_rst_wins", level, 0);
        gap_to_tick(g);
        check("s6_base_period", g, BASE_DIV);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        repeat (4) step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        check("s6_reset_tick", tick, 0);
        check("s6_reset_blink", blink, 0);
        check("s6_reset_level", level, 0);
        check("s6_reset_at_max", at_max, 0);

        // Random control traffic against the model.
        for (int k = 0; k < 600; k++) begin
            r = $urandom_range(999, 0);
            step(($urandom_range(99, 0) < 85) ? 1'b1 : 1'b0,
                 ($urandom_range(99, 0) < 6)  ? 1'b1 : 1'b0,
                 ($urandom_range(99, 0) < 2)  ? 1'b1 : 1'b0,
                 (r < 5) ? 1'b1 : 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
